// File: rtl/lsu_mem_access.sv
// Load/store unit for the MEM stage: one bus transaction per memory op, IDLE -> BUSY -> DONE.
// Optional alignment checking is enabled by defining LSU_MISALIGN_CHK_EN.
module lsu_mem_access (
  input  logic        clk_100MHz,
  input  logic        arst_n,
  input  logic [31:0] inst_i,
  input  logic        mem_r_ena_i,
  input  logic        mem_w_ena_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_w_data_i,
  input  logic        reg_w_ena_i,
  input  logic [4:0]  reg_w_addr_i,
  input  logic [31:0] reg_w_data_i,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_rdata_i,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  output logic [3:0]  bus_wstrb_o,
  output logic        hold_req_o,
  output logic [31:0] inst_o,
  output logic        reg_w_ena_o,
  output logic [4:0]  reg_w_addr_o,
  output logic [31:0] reg_w_data_o,
  output logic        misalign_o
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state, state_nxt;
  logic [31:0] addr_q, wdata_q, load_q;
  logic [3:0]  wstrb_q;
  logic [2:0]  funct3_q;
  logic        we_q;

  logic [2:0]  funct3;
  logic        mem_op, misaligned, start;
  logic [3:0]  wstrb_new;
  logic [31:0] wdata_new;

  assign funct3 = inst_i[14:12];
  assign mem_op = mem_r_ena_i | mem_w_ena_i;

`ifdef LSU_MISALIGN_CHK_EN
  always_comb begin
    misaligned = 1'b0;
    if (mem_op) begin
      unique case (funct3)
        3'b001, 3'b101: misaligned = mem_addr_i[0];
        3'b010:         misaligned = |mem_addr_i[1:0];
        default:        misaligned = 1'b0;
      endcase
    end
  end
`else
  assign misaligned = 1'b0;
`endif

  assign start = (state == IDLE) && mem_op && !misaligned;

  // Narrow stores replicate the datum across lanes so the strobes alone select the bytes.
  always_comb begin
    unique case (funct3)
      3'b000: begin
        wstrb_new = 4'b0001 << mem_addr_i[1:0];
        wdata_new = {4{mem_w_data_i[7:0]}};
      end
      3'b001: begin
        wstrb_new = 4'b0011 << {mem_addr_i[1], 1'b0};
        wdata_new = {2{mem_w_data_i[15:0]}};
      end
      default: begin
        wstrb_new = 4'b1111;
        wdata_new = mem_w_data_i;
      end
    endcase
  end

  function automatic logic [31:0] fmt_load(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    unique case (f3)
      3'b000:  fmt_load = {{24{b[7]}}, b};
      3'b001:  fmt_load = {{16{h[15]}}, h};
      3'b100:  fmt_load = {24'h0, b};
      3'b101:  fmt_load = {16'h0, h};
      default: fmt_load = w;
    endcase
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_100MHz or negedge arst_n) begin
    if (!arst_n) begin
      state    <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      load_q   <= '0;
      wstrb_q  <= '0;
      funct3_q <= '0;
      we_q     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start) begin
        addr_q   <= mem_addr_i;
        we_q     <= mem_w_ena_i;
        funct3_q <= funct3;
        wstrb_q  <= mem_w_ena_i ? wstrb_new : 4'b0000;
        wdata_q  <= mem_w_ena_i ? wdata_new : 32'h0;
      end
      if (state == BUSY && bus_ack_i && !we_q)
        load_q <= fmt_load(funct3_q, addr_q[1:0], bus_rdata_i);
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt    = state;
    hold_req_o   = 1'b0;
    misalign_o   = 1'b0;
    inst_o       = inst_i;
    reg_w_ena_o  = reg_w_ena_i;
    reg_w_addr_o = reg_w_addr_i;
    reg_w_data_o = reg_w_data_i;
    unique case (state)
      IDLE: begin
        if (misaligned) begin
          misalign_o  = 1'b1;
          reg_w_ena_o = 1'b0;
        end else if (mem_op) begin
          hold_req_o  = 1'b1;
          reg_w_ena_o = 1'b0;
          state_nxt   = BUSY;
        end
      end
      BUSY: begin
        hold_req_o  = 1'b1;
        reg_w_ena_o = 1'b0;
        if (bus_ack_i) state_nxt = DONE;
      end
      DONE: begin
        if (!we_q) reg_w_data_o = load_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Reset blanks the combinational pass-through path as well as the registers.
    if (!arst_n) begin
      hold_req_o   = 1'b0;
      misalign_o   = 1'b0;
      inst_o       = 32'h0;
      reg_w_ena_o  = 1'b0;
      reg_w_addr_o = 5'h0;
      reg_w_data_o = 32'h0;
    end
  end

  assign bus_req_o   = (state == BUSY);
  assign bus_we_o    = we_q;
  assign bus_addr_o  = {addr_q[31:2], 2'b00};
  assign bus_wdata_o = wdata_q;
  assign bus_wstrb_o = wstrb_q;

endmodule
